pipelined_adder_tree: RTL

Pipelined, signed, parametrised successor to the combinational AdderTree. It reduces LENGTH signed addends per beat through a registered binary tree. An accumulator can then sum the results of several consecutive beats into one output, which suits dot-product and convolution reductions. Valid/ready handshakes with full back-pressure on both sides let it sit between a streaming operand source and the downstream result consumer.

---
 rtl/pipelined_adder_tree_if.sv | 34 +++
 rtl/pipelined_adder_tree.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/pipelined_adder_tree_if.sv
// Stream interface for pipelined_adder_tree.
// Carries one beat of signed addends with valid/last/ready on the input side and the
// signed group sum with valid/ready on the output side.
//   in_addends : LENGTH signed addends of DATA_WIDTH bits
//   in_valid   : beat present
//   in_last    : beat closes an accumulation group
//   in_ready   : beat accepted when in_valid && in_ready
//   out_sum    : signed group sum, OUT_WIDTH bits
//   out_valid  : result present
//   out_ready  : consumer takes the result when out_valid && out_ready
// master: operand source plus result consumer. slave: the adder tree.
interface pipelined_adder_tree_if #(
  parameter int unsigned DATA_WIDTH = 5,
  parameter int unsigned LENGTH     = 9,
  parameter int unsigned OUT_WIDTH  = 13
);
  logic signed [DATA_WIDTH-1:0] in_addends [LENGTH];
  logic                         in_valid;
  logic                         in_last;
  logic                         in_ready;
  logic signed [OUT_WIDTH-1:0]  out_sum;
  logic                         out_valid;
  logic                         out_ready;

  modport master (
    output in_addends, in_valid, in_last, out_ready,
    input  in_ready, out_sum, out_valid
  );

  modport slave (
    input  in_addends, in_valid, in_last, out_ready,
    output in_ready, out_sum, out_valid
  );
endinterface

// File: rtl/pipelined_adder_tree.sv
// Pipelined signed adder tree with multi-beat accumulation.
// Each accepted beat of LENGTH signed addends is reduced through LEVELS registered pairwise
// adder levels; an accumulate register then sums tree results until a beat flagged last,
// which publishes the group sum. A single global stall (result held, consumer not ready)
// freezes every register; in_ready is its inverse, so there is no skid buffer.
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : pipelined_adder_tree_if.slave (addends/valid/last/ready in, sum/valid/ready out)
// Build option: define ADDER_TREE_SATURATE_EN to clamp the accumulator and output to the
// OUT_WIDTH signed range instead of wrapping.
module pipelined_adder_tree #(
  parameter int unsigned DATA_WIDTH = 5,
  parameter int unsigned LENGTH     = 9,
  parameter int unsigned ACC_BITS   = 4
) (
  input logic                   clk,
  input logic                   reset,
  pipelined_adder_tree_if.slave bus
);
  localparam int unsigned LEVELS    = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam int unsigned OUT_WIDTH = DATA_WIDTH + $clog2(LENGTH) + ACC_BITS;
  // Every node is kept at the root width; level k values only ever need DATA_WIDTH+k bits,
  // so the wider arithmetic gives identical results and never overflows.
  localparam int unsigned TREE_W    = DATA_WIDTH + LEVELS;

  // Nodes present at level k (level 0 = the raw addends).
  function automatic int unsigned level_cnt(int unsigned k);
    return (LENGTH + (32'd1 << k) - 32'd1) >> k;
  endfunction

  // Index of the first level-k node in the flat node register array (k >= 1).
  function automatic int unsigned level_off(int unsigned k);
    int unsigned s;
    s = 0;
    for (int unsigned i = 1; i < k; i++) s += level_cnt(i);
    return s;
  endfunction

  localparam int unsigned NODES = level_off(LEVELS + 1);

  logic                        stall;
  logic signed [TREE_W-1:0]    leaf   [LENGTH];
  logic signed [TREE_W-1:0]    node_d [NODES];
  logic signed [TREE_W-1:0]    node_q [NODES];
  logic [LEVELS-1:0]           vld_q;
  logic [LEVELS-1:0]           last_q;
  logic signed [OUT_WIDTH-1:0] tree_ow;
  logic signed [OUT_WIDTH-1:0] acc_sum;
  logic signed [OUT_WIDTH-1:0] acc_q, acc_d;
  logic signed [OUT_WIDTH-1:0] out_sum_q, out_sum_d;
  logic                        out_valid_q, out_valid_d;

  assign stall         = out_valid_q & ~bus.out_ready;
  assign bus.in_ready  = ~stall;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;

  for (genvar i = 0; i < LENGTH; i++) begin : g_leaf
    assign leaf[i] = {{LEVELS{bus.in_addends[i][DATA_WIDTH-1]}}, bus.in_addends[i]};
  end

  // Level k adds adjacent pairs of level k-1; an odd leftover adds zero, i.e. passes through.
  for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
    localparam int unsigned SrcCnt = level_cnt(k - 1);
    localparam int unsigned DstOff = level_off(k);
    for (genvar j = 0; j < level_cnt(k); j++) begin : g_node
      logic signed [TREE_W-1:0] lhs, rhs;
      if (k == 1) begin : g_from_leaf
        assign lhs = leaf[2*j];
        if (2*j + 1 < SrcCnt) begin : g_pair
          assign rhs = leaf[2*j+1];
        end else begin : g_odd
          assign rhs = '0;
        end
      end else begin : g_from_node
        localparam int unsigned SrcOff = level_off(k - 1);
        assign lhs = node_q[SrcOff+2*j];
        if (2*j + 1 < SrcCnt) begin : g_pair
          assign rhs = node_q[SrcOff+2*j+1];
        end else begin : g_odd
          assign rhs = '0;
        end
      end
      assign node_d[DstOff+j] = lhs + rhs;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q  <= '0;
      last_q <= '0;
      for (int i = 0; i < NODES; i++) node_q[i] <= '0;
    end else if (!stall) begin
      vld_q[0]  <= bus.in_valid;
      last_q[0] <= bus.in_last;
      for (int i = 1; i < LEVELS; i++) begin
        vld_q[i]  <= vld_q[i-1];
        last_q[i] <= last_q[i-1];
      end
      for (int i = 0; i < NODES; i++) node_q[i] <= node_d[i];
    end
  end

  // Root is sign-extended (or, for LENGTH=1 with no headroom, trimmed) to the output width.
  assign tree_ow = OUT_WIDTH'(node_q[NODES-1]);

`ifdef ADDER_TREE_SATURATE_EN
  logic signed [OUT_WIDTH:0] wide_sum;
  assign wide_sum = {acc_q[OUT_WIDTH-1], acc_q} + {tree_ow[OUT_WIDTH-1], tree_ow};

  // Top two bits disagreeing means the true sum left the OUT_WIDTH range.
  always_comb begin
    acc_sum = wide_sum[OUT_WIDTH-1:0];
    if (wide_sum[OUT_WIDTH] != wide_sum[OUT_WIDTH-1]) begin
      acc_sum = wide_sum[OUT_WIDTH] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                    : {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end
  end
`else
  assign acc_sum = acc_q + tree_ow;
`endif

  always_comb begin
    acc_d       = acc_q;
    out_sum_d   = out_sum_q;
    out_valid_d = out_valid_q;
    if (!stall) begin
      // Not stalled: any held result is consumed on this edge.
      out_valid_d = 1'b0;
      if (vld_q[LEVELS-1]) begin
        if (last_q[LEVELS-1]) begin
          out_sum_d   = acc_sum;
          out_valid_d = 1'b1;
          acc_d       = '0;
        end else begin
          acc_d = acc_sum;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q       <= '0;
      out_sum_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      out_sum_q   <= out_sum_d;
      out_valid_q <= out_valid_d;
    end
  end
endmodule
